// File: rtl/spdif_encoder_if.sv
// Sample-pair handshake between a PCM source and the S/PDIF encoder.
// The master offers a left/right pair; the slave accepts it when valid & ready.
interface spdif_encoder_if;
   logic [23:0] sample_l;
   logic [23:0] sample_r;
   logic        sample_valid;
   logic        sample_ready;

   modport master (
      output sample_l,
      output sample_r,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_l,
      input  sample_r,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/spdif_encoder.sv
// IEC 60958 transmitter: frames 24-bit L/R pairs into B/M/W subframes and
// drives a biphase-mark coded line with HALF_CELL clocks per cell.
module spdif_encoder #(
   parameter int unsigned HALF_CELL    = 16,
   parameter int unsigned BLOCK_FRAMES = 192
) (
   input  logic            clk,
   input  logic            reset,
   spdif_encoder_if.slave  bus,
   input  logic [7:0]      cs_byte0,
   output logic            tx_out,
   output logic            frame_start,
   output logic            underrun
);
   localparam int unsigned FC_W = (BLOCK_FRAMES > 8) ? $clog2(BLOCK_FRAMES) : 4;

   // Cell 0 is the MSB; patterns assume the line sat at 0 before the preamble.
   localparam logic [7:0] PRE_B = 8'b1110_1000;
   localparam logic [7:0] PRE_M = 8'b1110_0010;
   localparam logic [7:0] PRE_W = 8'b1110_0100;

   typedef enum logic {CH_L, CH_R} chan_t;

   chan_t           chan_q, chan_d;
   logic [7:0]      cell_cnt_q, cell_cnt_d;
   logic [5:0]      cell_idx_q, cell_idx_d;
   logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [23:0]     hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic            hold_full_q, hold_full_d;
   logic [23:0]     smp_l_q, smp_l_d, smp_r_q, smp_r_d;
   logic            inval_q, inval_d;
   logic            tx_q, tx_d;
   logic            line_lvl_q, line_lvl_d;
   logic            frame_start_q, frame_start_d;
   logic            underrun_q, underrun_d;

   logic            cell_start, load, xfer;
   logic [23:0]     aud;
   logic [4:0]      slot, aud_idx;
   logic            cs_bit, parity, slot_bit, lvl_prev;
   logic [7:0]      pre_pat;

   always_comb begin
      cell_start    = (cell_cnt_q == 8'd0);
      load          = cell_start && (cell_idx_q == 6'd0) && (chan_q == CH_L);
      xfer          = bus.sample_valid && !hold_full_q;

      cell_cnt_d    = cell_cnt_q + 8'd1;
      cell_idx_d    = cell_idx_q;
      chan_d        = chan_q;
      frame_cnt_d   = frame_cnt_q;
      if (cell_cnt_q == 8'(HALF_CELL - 1)) begin
         cell_cnt_d = '0;
         cell_idx_d = cell_idx_q + 6'd1;
         if (cell_idx_q == 6'd63) begin
            case (chan_q)
               CH_L: chan_d = CH_R;
               CH_R: begin
                  chan_d      = CH_L;
                  frame_cnt_d = (frame_cnt_q == FC_W'(BLOCK_FRAMES - 1)) ? '0
                                                                         : frame_cnt_q + FC_W'(1);
               end
               default: chan_d = CH_L;
            endcase
         end
      end

      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      if (xfer) begin
         hold_l_d = bus.sample_l;
         hold_r_d = bus.sample_r;
      end
      // A load drains the register; a same-edge transfer can only land when it was empty.
      hold_full_d   = xfer || (hold_full_q && !load);

      smp_l_d       = smp_l_q;
      smp_r_d       = smp_r_q;
      inval_d       = inval_q;
      if (load) begin
         smp_l_d = hold_full_q ? hold_l_q : '0;
         smp_r_d = hold_full_q ? hold_r_q : '0;
         inval_d = !hold_full_q;
      end
      underrun_d    = load && !hold_full_q;
      frame_start_d = load && (frame_cnt_q == '0);

      aud      = (chan_q == CH_R) ? smp_r_q : smp_l_q;
      slot     = cell_idx_q[5:1];
      aud_idx  = slot - 5'd4;
      cs_bit   = (frame_cnt_q < FC_W'(8)) ? cs_byte0[frame_cnt_q[2:0]] : 1'b0;
      parity   = (^aud) ^ inval_q ^ cs_bit;
      case (slot)
         5'd28:   slot_bit = inval_q;
         5'd29:   slot_bit = 1'b0;
         5'd30:   slot_bit = cs_bit;
         5'd31:   slot_bit = parity;
         default: slot_bit = aud[aud_idx];
      endcase

      if (chan_q == CH_R)            pre_pat = PRE_W;
      else if (frame_cnt_q == '0)    pre_pat = PRE_B;
      else                           pre_pat = PRE_M;

      lvl_prev   = (cell_idx_q == 6'd0) ? tx_q : line_lvl_q;
      line_lvl_d = (cell_start && cell_idx_q == 6'd0) ? tx_q : line_lvl_q;

      tx_d = tx_q;
      if (cell_start) begin
         if (cell_idx_q < 6'd8)  tx_d = pre_pat[3'd7 - cell_idx_q[2:0]] ^ lvl_prev;
         else if (!cell_idx_q[0]) tx_d = !tx_q;
         else                     tx_d = tx_q ^ slot_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         chan_q        <= CH_L;
         cell_cnt_q    <= '0;
         cell_idx_q    <= '0;
         frame_cnt_q   <= '0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         hold_full_q   <= 1'b0;
         smp_l_q       <= '0;
         smp_r_q       <= '0;
         inval_q       <= 1'b0;
         tx_q          <= 1'b0;
         line_lvl_q    <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         chan_q        <= chan_d;
         cell_cnt_q    <= cell_cnt_d;
         cell_idx_q    <= cell_idx_d;
         frame_cnt_q   <= frame_cnt_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         hold_full_q   <= hold_full_d;
         smp_l_q       <= smp_l_d;
         smp_r_q       <= smp_r_d;
         inval_q       <= inval_d;
         tx_q          <= tx_d;
         line_lvl_q    <= line_lvl_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign bus.sample_ready = !hold_full_q;
   assign tx_out           = tx_q;
   assign frame_start      = frame_start_q;
   assign underrun         = underrun_q;
endmodule

// File: tb/tb_spdif_encoder.sv
// Directed bench for spdif_encoder: captures whole frames off tx_out,
// decodes the biphase-mark cells and checks them against hand-derived values.
module tb_spdif_encoder;
   localparam int HC = 4;
   localparam int BF = 4;

   localparam logic [7:0] P_B = 8'b1110_1000;
   localparam logic [7:0] P_M = 8'b1110_0010;
   localparam logic [7:0] P_W = 8'b1110_0100;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] cs_byte0;
   logic       tx_out, frame_start, underrun;
   logic       prev_lvl = 1'b0;
   int         checks = 0;
   int         errors = 0;

   spdif_encoder_if bus ();

   spdif_encoder #(.HALF_CELL(HC), .BLOCK_FRAMES(BF)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .cs_byte0    (cs_byte0),
      .tx_out      (tx_out),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_sub(input string tag, input logic [63:0] sub, input logic [7:0] exp_pre,
                            input logic [23:0] exp_aud, input logic exp_v, input logic exp_c,
                            input logic exp_p);
      logic [7:0]  pre;
      logic [27:0] bits;
      int          bmc_err;
      bmc_err = 0;
      for (int k = 0; k < 8; k++) pre[7-k] = sub[k];
      for (int s = 4; s < 32; s++) begin
         if (sub[2*s] == sub[2*s-1]) bmc_err++;
         bits[s-4] = sub[2*s] ^ sub[2*s+1];
      end
      chk({tag, " preamble"}, 32'(pre), 32'(exp_pre ^ {8{prev_lvl}}));
      chk({tag, " audio"},    32'(bits[23:0]), 32'(exp_aud));
      chk({tag, " V"},        32'(bits[24]), 32'(exp_v));
      chk({tag, " U"},        32'(bits[25]), 32'(1'b0));
      chk({tag, " C"},        32'(bits[26]), 32'(exp_c));
      chk({tag, " P"},        32'(bits[27]), 32'(exp_p));
      chk({tag, " even"},     32'(^bits), 32'(1'b0));
      chk({tag, " bmc"},      32'(bmc_err), 32'(0));
      chk({tag, " level"},    32'(sub[63]), 32'(prev_lvl));
      prev_lvl = sub[63];
   endtask

   // Entered on the negedge just after a frame's load edge; leaves at the next one.
   task automatic run_frame(input string tag, input logic exp_b, input logic exp_ur,
                            input int exp_rdy, input logic [23:0] al, input logic [23:0] ar,
                            input logic exp_c, input logic pl, input logic pr);
      logic [127:0] cells;
      int fs_n, ur_n, rdy_n, unstable;
      logic fs0, ur0, rdy0;
      fs_n = 0; ur_n = 0; rdy_n = 0; unstable = 0;
      fs0 = frame_start; ur0 = underrun; rdy0 = bus.sample_ready;
      for (int c = 0; c < 128*HC; c++) begin
         if (c % HC == 0) cells[c/HC] = tx_out;
         else if (tx_out !== cells[c/HC]) unstable++;
         if (frame_start) fs_n++;
         if (underrun) ur_n++;
         if (bus.sample_ready) rdy_n++;
         @(negedge clk);
      end
      chk({tag, " fs_first"},  32'(fs0), 32'(exp_b));
      chk({tag, " fs_count"},  32'(fs_n), 32'(exp_b));
      chk({tag, " ur_first"},  32'(ur0), 32'(exp_ur));
      chk({tag, " ur_count"},  32'(ur_n), 32'(exp_ur));
      chk({tag, " rdy_first"}, 32'(rdy0), 32'(exp_rdy != 0));
      chk({tag, " rdy_count"}, 32'(rdy_n), 32'(exp_rdy));
      chk({tag, " unstable"},  32'(unstable), 32'(0));
      check_sub({tag, ".L"}, cells[63:0],   exp_b ? P_B : P_M, al, exp_ur, exp_c, pl);
      check_sub({tag, ".R"}, cells[127:64], P_W,               ar, exp_ur, exp_c, pr);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      reset            = 1'b1;
      cs_byte0         = 8'h04;
      bus.sample_valid = 1'b1;
      bus.sample_l     = 24'h000001;
      bus.sample_r     = 24'h800000;
      repeat (3) @(negedge clk);
      chk("rst tx_out",      32'(tx_out), 32'(1'b0));
      chk("rst ready",       32'(bus.sample_ready), 32'(1'b1));
      chk("rst frame_start", 32'(frame_start), 32'(1'b0));
      chk("rst underrun",    32'(underrun), 32'(1'b0));
      reset = 1'b0;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      chk("first cell", 32'(tx_out), 32'(1'b1));
      // Frame 0 is an underrun; the pair offered at the load edge goes out in frame 1.
      run_frame("F0", 1'b1, 1'b1, 0, 24'h000000, 24'h000000, 1'b0, 1'b1, 1'b1);
      bus.sample_valid = 1'b1;
      bus.sample_l     = 24'hA5A5A5;
      bus.sample_r     = 24'h5A5A5A;
      run_frame("F1", 1'b0, 1'b0, 1, 24'h000001, 24'h800000, 1'b0, 1'b1, 1'b1);
      run_frame("F2", 1'b0, 1'b0, 1, 24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b1, 1'b1);
      run_frame("F3", 1'b0, 1'b0, 1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, 1'b0);
      run_frame("F4", 1'b1, 1'b0, 1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, 1'b0);
      run_frame("F5", 1'b0, 1'b0, 1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, 1'b0);
      // Cycle 404 of the frame falls in cell 101, i.e. cell_idx 37 of the R subframe.
      repeat (404) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid rst tx_out",      32'(tx_out), 32'(1'b0));
      chk("mid rst ready",       32'(bus.sample_ready), 32'(1'b1));
      chk("mid rst frame_start", 32'(frame_start), 32'(1'b0));
      chk("mid rst underrun",    32'(underrun), 32'(1'b0));
      prev_lvl = 1'b0;
      @(negedge clk);
      run_frame("R0", 1'b1, 1'b1, 0, 24'h000000, 24'h000000, 1'b0, 1'b1, 1'b1);
      run_frame("R1", 1'b0, 1'b0, 1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
